id_ex_stage: RTL and testbench

- Pipeline register between decode (register-file read) and execute.
- Captures operands, immediate, destination and control bundle each cycle, with a one-cycle latency.
- Corrects operands for a same-cycle writeback.
- Detects load-use hazards and inserts bubbles.
- Supports flush (branch mispredict) and downstream stall.

---
 rtl/id_ex_stage_pkg.sv | 46 ++++
 rtl/id_ex_stage_hazard_unit.sv | 20 ++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and helpers for the ID/EX boundary: control bundle layout,
// ALU op encodings and the register-width sign extension used by writeback.
package id_ex_stage_pkg;

    localparam int ID_EX_DATA_W = 64;
    localparam int ID_EX_REG_W  = 32;
    localparam int ID_EX_ADDR_W = 5;
    localparam int ID_EX_CTRL_W = 9;
    localparam int ID_EX_CNT_W  = 16;

    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_ALU_OP_MSB = 3;
    localparam int CTRL_ALU_OP_LSB = 0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    // The register file only stores REG_W bits; anything read back is sign-extended.
    function automatic logic [ID_EX_DATA_W-1:0] sign_extend_reg(input logic [ID_EX_REG_W-1:0] v);
        return {{(ID_EX_DATA_W-ID_EX_REG_W){v[ID_EX_REG_W-1]}}, v};
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use detector: the instruction in EX is a load whose result the
// instruction in decode needs, so it cannot be forwarded in time.
module hazard_unit
    import id_ex_stage_pkg::*;
#(
    parameter int ADDR_W = ID_EX_ADDR_W
) (
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              ex_valid,
    input  ctrl_t             ex_ctrl,
    input  logic [ADDR_W-1:0] ex_rd,
    output logic              hazard
);

    assign hazard = id_valid & ex_valid & ex_ctrl.mem_read & ex_ctrl.reg_write
                  & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass on capture and while holding,
// load-use bubble insertion, flush, downstream stall and a saturating stall counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int REG_W  = ID_EX_REG_W,
    parameter int ADDR_W = ID_EX_ADDR_W,
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int CNT_W  = ID_EX_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0] id_read_data_1,
    input  logic [DATA_W-1:0] id_read_data_2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] ex_rs1,
    output logic [ADDR_W-1:0] ex_rs2,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_read_data_1,
    output logic [DATA_W-1:0] ex_read_data_2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              id_stall,
    output logic [CNT_W-1:0]  load_use_stalls
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, imm_q, imm_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              hazard;
    logic [DATA_W-1:0] wb_ext;
    logic              byp_id1, byp_id2, byp_ex1, byp_ex2;

    hazard_unit #(.ADDR_W(ADDR_W)) u_hazard (
        .id_valid (id_valid),
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .ex_valid (valid_q),
        .ex_ctrl  (ctrl_q),
        .ex_rd    (rd_q),
        .hazard   (hazard)
    );

    assign wb_ext  = sign_extend_reg(wb_data[REG_W-1:0]);
    assign byp_id1 = wb_reg_write && (wb_rd == id_rs1);
    assign byp_id2 = wb_reg_write && (wb_rd == id_rs2);
    assign byp_ex1 = wb_reg_write && (wb_rd == rs1_q);
    assign byp_ex2 = wb_reg_write && (wb_rd == rs2_q);

    // Asserted even under flush; upstream resolves that priority.
    assign id_stall = hazard | ex_stall;

    always_comb begin
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            d1_d    = '0;
            d2_d    = '0;
            imm_d   = '0;
        end else if (ex_stall || hazard) begin
            // Held operands would go stale if their register is written meanwhile.
            if (byp_ex1) d1_d = wb_ext;
            if (byp_ex2) d2_d = wb_ext;
            if (!ex_stall) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d = id_valid;
            rs1_d   = id_rs1;
            rs2_d   = id_rs2;
            rd_d    = id_rd;
            d1_d    = byp_id1 ? wb_ext : id_read_data_1;
            d2_d    = byp_id2 ? wb_ext : id_read_data_2;
            imm_d   = id_imm;
            ctrl_d  = id_valid ? ctrl_t'(id_ctrl) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid        = valid_q;
    assign ex_rs1          = rs1_q;
    assign ex_rs2          = rs2_q;
    assign ex_rd           = rd_q;
    assign ex_read_data_1  = d1_q;
    assign ex_read_data_2  = d2_q;
    assign ex_imm          = imm_q;
    assign ex_ctrl         = ctrl_q;
    assign load_use_stalls = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued per step and
// compared after each edge; a narrow-counter instance covers saturation.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam logic [8:0] C_LOAD = 9'h1B0;  // reg_write, mem_read, mem_to_reg, alu_src, ADD
    localparam logic [8:0] C_ALU  = 9'h101;  // reg_write, SUB
    localparam int         SAT_W  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [63:0] id_read_data_1, id_read_data_2, id_imm;
    logic [8:0]  id_ctrl;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush, ex_stall;

    logic        ex_valid, id_stall;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [63:0] ex_read_data_1, ex_read_data_2, ex_imm;
    logic [8:0]  ex_ctrl;
    logic [15:0] load_use_stalls;

    logic        s_ex_valid, s_id_stall;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [63:0] s_ex_read_data_1, s_ex_read_data_2, s_ex_imm;
    logic [8:0]  s_ex_ctrl;
    logic [SAT_W-1:0] s_load_use_stalls;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_read_data_1(ex_read_data_1),
        .ex_read_data_2(ex_read_data_2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .id_stall(id_stall), .load_use_stalls(load_use_stalls)
    );

    id_ex_stage #(.CNT_W(SAT_W)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .ex_stall(ex_stall), .ex_valid(s_ex_valid),
        .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_read_data_1(s_ex_read_data_1),
        .ex_read_data_2(s_ex_read_data_2), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl),
        .id_stall(s_id_stall), .load_use_stalls(s_load_use_stalls)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] d1, d2, imm;
        logic [8:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                       input logic [8:0] ctrl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_read_data_1 = d1; id_read_data_2 = d2; id_imm = imm; id_ctrl = ctrl;
    endtask

    task automatic push(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                        input logic [8:0] ctrl);
        exp_t e;
        e.v = v; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.d1 = d1; e.d2 = d2; e.imm = imm; e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [63:0] data);
        wb_reg_write = we; wb_rd = rd; wb_data = data;
    endtask

    // One clock edge, then compare the EX slot against the oldest queued expectation.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s.sb_empty: observed 0 entries expected 1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".valid"}, 64'(ex_valid), 64'(e.v));
            chk({tag, ".rs1"},   64'(ex_rs1),   64'(e.rs1));
            chk({tag, ".rs2"},   64'(ex_rs2),   64'(e.rs2));
            chk({tag, ".rd"},    64'(ex_rd),    64'(e.rd));
            chk({tag, ".d1"},    ex_read_data_1, e.d1);
            chk({tag, ".d2"},    ex_read_data_2, e.d2);
            chk({tag, ".imm"},   ex_imm,        e.imm);
            chk({tag, ".ctrl"},  64'(ex_ctrl),  64'(e.ctrl));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; ex_stall = 1'b0;
        wb(0, 0, 0);
        drv(1, 3, 3, 3, 64'h99, 64'h99, 64'h99, C_LOAD);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        tick("reset");
        chk("reset.cnt", 64'(load_use_stalls), 0);
        chk("reset.sat_cnt", 64'(s_load_use_stalls), 0);
        reset = 1'b0;

        // Normal capture
        drv(1, 3, 4, 7, 64'h11, 64'h22, 64'h8, C_ALU);
        #1 chk("normal.id_stall", 64'(id_stall), 0);
        push(1, 3, 4, 7, 64'h11, 64'h22, 64'h8, C_ALU);
        tick("normal");

        // Same-cycle bypass, port 1 only, negative 32-bit value
        drv(1, 5, 6, 8, 64'h7, 64'h9, 64'h0, C_ALU);
        wb(1, 5, 64'h1_8000_0000);
        push(1, 5, 6, 8, 64'hFFFF_FFFF_8000_0000, 64'h9, 64'h0, C_ALU);
        tick("byp1");

        // Both ports bypass; upper wb bits are discarded
        drv(1, 5, 5, 8, 64'h7, 64'h9, 64'h4, C_ALU);
        wb(1, 5, 64'hAAAA_0000_1234_5678);
        push(1, 5, 5, 8, 64'h1234_5678, 64'h1234_5678, 64'h4, C_ALU);
        tick("byp2");

        // Register 0 bypasses like any other index
        drv(1, 0, 1, 0, 64'h3, 64'h4, 64'h5, C_ALU);
        wb(1, 0, 64'hFFFF_FFFF);
        push(1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4, 64'h5, C_ALU);
        tick("byp_r0");
        wb(0, 0, 0);

        // Invalid decode slot: fields captured, ctrl zeroed
        drv(0, 1, 2, 3, 64'h44, 64'h55, 64'h66, C_LOAD);
        push(0, 1, 2, 3, 64'h44, 64'h55, 64'h66, 9'h0);
        tick("invalid");

        // Load-use via rs2
        drv(1, 1, 2, 6, 64'hA, 64'hB, 64'h10, C_LOAD);
        push(1, 1, 2, 6, 64'hA, 64'hB, 64'h10, C_LOAD);
        tick("ld");
        drv(1, 7, 6, 9, 64'hC, 64'hD, 64'h20, C_ALU);
        #1 chk("lu.id_stall", 64'(id_stall), 1);
        push(0, 1, 2, 6, 64'hA, 64'hB, 64'h10, 9'h0);
        tick("lu.bubble");
        chk("lu.cnt", 64'(load_use_stalls), 1);
        chk("lu.id_stall_after", 64'(id_stall), 0);
        push(1, 7, 6, 9, 64'hC, 64'hD, 64'h20, C_ALU);
        tick("lu.capture");
        chk("lu.cnt_hold", 64'(load_use_stalls), 1);

        // ex_stall hold with writeback refresh of the held rs1 operand
        drv(1, 9, 10, 11, 64'h1, 64'h2, 64'h30, C_ALU);
        push(1, 9, 10, 11, 64'h1, 64'h2, 64'h30, C_ALU);
        tick("st.load");
        ex_stall = 1'b1;
        drv(1, 12, 13, 14, 64'hEE, 64'hFF, 64'h0, C_ALU);
        #1 chk("st.id_stall", 64'(id_stall), 1);
        push(1, 9, 10, 11, 64'h1, 64'h2, 64'h30, C_ALU);
        tick("st.c1");
        wb(1, 9, 64'h55);
        push(1, 9, 10, 11, 64'h55, 64'h2, 64'h30, C_ALU);
        tick("st.c2");
        wb(0, 0, 0);
        push(1, 9, 10, 11, 64'h55, 64'h2, 64'h30, C_ALU);
        tick("st.c3");
        chk("st.cnt", 64'(load_use_stalls), 1);
        ex_stall = 1'b0;
        push(1, 12, 13, 14, 64'hEE, 64'hFF, 64'h0, C_ALU);
        tick("st.release");

        // Flush while hazard is present
        drv(1, 1, 2, 6, 64'hA, 64'hB, 64'h10, C_LOAD);
        push(1, 1, 2, 6, 64'hA, 64'hB, 64'h10, C_LOAD);
        tick("fl.ld");
        drv(1, 6, 3, 4, 64'h1, 64'h2, 64'h3, C_ALU);
        flush = 1'b1;
        #1 chk("fl.id_stall", 64'(id_stall), 1);
        push(0, 0, 0, 0, 0, 0, 0, 9'h0);
        tick("fl");
        chk("fl.cnt", 64'(load_use_stalls), 1);
        flush = 1'b0;

        // Hazard under ex_stall is not counted; then reset mid-stall
        drv(1, 1, 2, 6, 64'hA, 64'hB, 64'h10, C_LOAD);
        push(1, 1, 2, 6, 64'hA, 64'hB, 64'h10, C_LOAD);
        tick("hs.ld");
        drv(1, 6, 3, 4, 64'h1, 64'h2, 64'h3, C_ALU);
        ex_stall = 1'b1;
        push(1, 1, 2, 6, 64'hA, 64'hB, 64'h10, C_LOAD);
        tick("hs.hold");
        chk("hs.cnt", 64'(load_use_stalls), 1);
        reset = 1'b1;
        push(0, 0, 0, 0, 0, 0, 0, 9'h0);
        tick("rst_mid");
        chk("rst_mid.cnt", 64'(load_use_stalls), 0);
        reset = 1'b0;
        ex_stall = 1'b0;

        // 20 hazards, alternating rs1/rs2 match; narrow counter must stick at 15
        for (int i = 0; i < 20; i++) begin
            drv(1, 1, 2, 6, 64'hA0, 64'hB0, 64'h40, C_LOAD);
            push(1, 1, 2, 6, 64'hA0, 64'hB0, 64'h40, C_LOAD);
            tick("sat.ld");
            if (i % 2 == 0) drv(1, 6, 3, 4, 64'h1, 64'h2, 64'h3, C_LOAD);
            else            drv(1, 3, 6, 4, 64'h1, 64'h2, 64'h3, C_LOAD);
            push(0, 1, 2, 6, 64'hA0, 64'hB0, 64'h40, 9'h0);
            tick("sat.bubble");
            if (i == 14) chk("sat.cnt15", 64'(s_load_use_stalls), 15);
        end
        chk("sat.main_cnt", 64'(load_use_stalls), 20);
        chk("sat.narrow_cnt", 64'(s_load_use_stalls), 15);
        push(1, 3, 6, 4, 64'h1, 64'h2, 64'h3, C_LOAD);
        tick("sat.drain");
        chk("sat.narrow_hold", 64'(s_load_use_stalls), 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
